// File: rtl/fetch.sv
// Instruction fetch stage: PC, in-order instruction memory reads and a small {pc, instr} FIFO.
// Optional FETCH_MISALIGN_TRAP_EN: a misaligned redirect target sets a sticky flag and halts issue.
module fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        o_imem_req_valid,
    output logic [31:0] o_imem_req_addr,
    input  logic        i_imem_req_ready,
    input  logic        i_imem_rsp_valid,
    input  logic [31:0] i_imem_rsp_data,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc,
    output logic        o_instr_valid,
    output logic [31:0] o_instr,
    output logic [31:0] o_pc,
    input  logic        i_instr_ready,
    output logic        o_misaligned
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    logic [31:0]      pc_q, pc_d;
    logic [31:0]      rsp_pc_q, rsp_pc_d;
    logic [CNT_W-1:0] outstanding_q, outstanding_d;
    logic [CNT_W-1:0] drop_q, drop_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [31:0]      buf_instr_q [DEPTH];
    logic [31:0]      buf_instr_d [DEPTH];
    logic [31:0]      buf_pc_q [DEPTH];
    logic [31:0]      buf_pc_d [DEPTH];
    logic             misaligned_q, misaligned_d;

    logic             halted;
    logic             pop;
    logic             push;
    logic             rsp_drop;
    logic             req_fire;
    logic [31:0]      target_pc;
    logic [CNT_W:0]   occupancy;

`ifdef FETCH_MISALIGN_TRAP_EN
    assign target_pc = i_redirect_pc;
    assign halted    = misaligned_q;
`else
    assign target_pc = i_redirect_pc & 32'hFFFF_FFFC;
    assign halted    = 1'b0;
`endif

    assign o_instr_valid = (count_q != '0);
    assign pop           = o_instr_valid && i_instr_ready && !i_redirect;
    assign rsp_drop      = (drop_q != '0);
    assign push          = i_imem_rsp_valid && !rsp_drop && !i_redirect;

    // A head leaving this cycle frees its slot, which keeps one instr/cycle at DEPTH=2.
    assign occupancy = {1'b0, outstanding_q} + {1'b0, count_q} - {{CNT_W{1'b0}}, pop};

    assign o_imem_req_valid = !rst && !i_redirect && !halted &&
                              (occupancy < (CNT_W+1)'(DEPTH));
    assign o_imem_req_addr  = pc_q;
    assign req_fire         = o_imem_req_valid && i_imem_req_ready;

    assign o_instr      = buf_instr_q[rd_ptr_q];
    assign o_pc         = buf_pc_q[rd_ptr_q];
    assign o_misaligned = misaligned_q;

    always_comb begin
        pc_d          = pc_q;
        rsp_pc_d      = rsp_pc_q;
        outstanding_d = outstanding_q;
        drop_d        = drop_q;
        count_d       = count_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        buf_instr_d   = buf_instr_q;
        buf_pc_d      = buf_pc_q;
        misaligned_d  = misaligned_q;

        if (req_fire) begin
            pc_d = pc_q + 32'd4;
        end

        case ({req_fire, i_imem_rsp_valid})
            2'b10:   outstanding_d = outstanding_q + CNT_W'(1);
            2'b01:   outstanding_d = outstanding_q - CNT_W'(1);
            default: outstanding_d = outstanding_q;
        endcase

        if (i_imem_rsp_valid && rsp_drop) begin
            drop_d = drop_q - CNT_W'(1);
        end

        if (push) begin
            buf_instr_d[wr_ptr_q] = i_imem_rsp_data;
            buf_pc_d[wr_ptr_q]    = rsp_pc_q;
            wr_ptr_d              = wr_ptr_q + PTR_W'(1);
            rsp_pc_d              = rsp_pc_q + 32'd4;
        end

        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        // Every request still in flight belongs to the wrong path and must be discarded.
        if (i_redirect) begin
            pc_d     = target_pc;
            rsp_pc_d = target_pc;
            count_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            drop_d   = outstanding_d;
`ifdef FETCH_MISALIGN_TRAP_EN
            if (i_redirect_pc[1:0] != 2'b00) begin
                misaligned_d = 1'b1;
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q          <= RESET_PC;
            rsp_pc_q      <= RESET_PC;
            outstanding_q <= '0;
            drop_q        <= '0;
            count_q       <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            misaligned_q  <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                buf_instr_q[i] <= '0;
                buf_pc_q[i]    <= RESET_PC;
            end
        end else begin
            pc_q          <= pc_d;
            rsp_pc_q      <= rsp_pc_d;
            outstanding_q <= outstanding_d;
            drop_q        <= drop_d;
            count_q       <= count_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            misaligned_q  <= misaligned_d;
            buf_instr_q   <= buf_instr_d;
            buf_pc_q      <= buf_pc_d;
        end
    end

endmodule

// File: tb/tb_fetch.sv
// Directed bench for fetch: in-order memory model with configurable latency, logs of
// accepted requests and consumed instructions, compared against hand-computed values.
module tb_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        o_imem_req_valid;
    logic [31:0] o_imem_req_addr;
    logic        i_imem_req_ready;
    logic        i_imem_rsp_valid;
    logic [31:0] i_imem_rsp_data;
    logic        i_redirect;
    logic [31:0] i_redirect_pc;
    logic        o_instr_valid;
    logic [31:0] o_instr;
    logic [31:0] o_pc;
    logic        i_instr_ready;
    logic        o_misaligned;

    // Second instance: wrapping reset PC, DEPTH=4, memory never responds.
    logic        req2Valid;
    logic [31:0] req2Addr;
    logic        req2Ready;
    logic        rsp2Valid;
    logic [31:0] rsp2Data;
    logic        redirect2;
    logic [31:0] redirect2Pc;
    logic        instr2Valid;
    logic [31:0] instr2;
    logic [31:0] pc2;
    logic        instr2Ready;
    logic        misaligned2;

    fetch #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
        .clk(clk), .rst(rst),
        .o_imem_req_valid(o_imem_req_valid), .o_imem_req_addr(o_imem_req_addr),
        .i_imem_req_ready(i_imem_req_ready),
        .i_imem_rsp_valid(i_imem_rsp_valid), .i_imem_rsp_data(i_imem_rsp_data),
        .i_redirect(i_redirect), .i_redirect_pc(i_redirect_pc),
        .o_instr_valid(o_instr_valid), .o_instr(o_instr), .o_pc(o_pc),
        .i_instr_ready(i_instr_ready), .o_misaligned(o_misaligned)
    );

    fetch #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(4)) dutWrap (
        .clk(clk), .rst(rst),
        .o_imem_req_valid(req2Valid), .o_imem_req_addr(req2Addr),
        .i_imem_req_ready(req2Ready),
        .i_imem_rsp_valid(rsp2Valid), .i_imem_rsp_data(rsp2Data),
        .i_redirect(redirect2), .i_redirect_pc(redirect2Pc),
        .o_instr_valid(instr2Valid), .o_instr(instr2), .o_pc(pc2),
        .i_instr_ready(instr2Ready), .o_misaligned(misaligned2)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } memReq_t;

    memReq_t     memQ[$];
    int          memLat;
    int          cyc;
    int          checkCount;
    int          errCount;

    logic [31:0] reqLog[$];
    int          reqCycLog[$];
    logic [31:0] popPcLog[$];
    logic [31:0] popInstrLog[$];
    int          popCycLog[$];
    logic [31:0] req2Log[$];

    logic        snapReqValid;
    logic [31:0] snapReqAddr;
    logic        snapInstrValid;
    logic [31:0] snapInstr;
    logic [31:0] snapPc;
    logic        snapMis;
    logic [31:0] snapPc2;

    function automatic logic [31:0] memWord(input logic [31:0] a);
        return a ^ 32'hCAFE_0000;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errCount++;
            $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
        end
    endtask

    // One clock cycle: drive inputs at the falling edge, sample just after, log what the rising edge commits.
    task automatic applyStimulus(input logic rstIn, input logic readyIn, input logic redirIn,
                                 input logic [31:0] redirPcIn);
        rst           = rstIn;
        i_instr_ready = readyIn;
        i_redirect    = redirIn;
        i_redirect_pc = redirPcIn;
        if (rstIn) memQ.delete();
        if (!rstIn && memQ.size() > 0 && memQ[0].due <= cyc) begin
            i_imem_rsp_valid = 1'b1;
            i_imem_rsp_data  = memWord(memQ[0].addr);
        end else begin
            i_imem_rsp_valid = 1'b0;
            i_imem_rsp_data  = 32'h0;
        end
        #1;
        snapReqValid   = o_imem_req_valid;
        snapReqAddr    = o_imem_req_addr;
        snapInstrValid = o_instr_valid;
        snapInstr      = o_instr;
        snapPc         = o_pc;
        snapMis        = o_misaligned;
        snapPc2        = pc2;
        if (rstIn) begin
            req2Log.delete();
        end else begin
            if (i_imem_rsp_valid) memQ.delete(0);
            if (o_imem_req_valid && i_imem_req_ready) begin
                memQ.push_back('{addr: o_imem_req_addr, due: cyc + memLat});
                reqLog.push_back(o_imem_req_addr);
                reqCycLog.push_back(cyc);
            end
            if (o_instr_valid && i_instr_ready && !i_redirect) begin
                popPcLog.push_back(o_pc);
                popInstrLog.push_back(o_instr);
                popCycLog.push_back(cyc);
            end
            if (req2Valid && req2Ready) req2Log.push_back(req2Addr);
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic clearLogs();
        reqLog.delete();
        reqCycLog.delete();
        popPcLog.delete();
        popInstrLog.delete();
        popCycLog.delete();
    endtask

    task automatic resetDut();
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        clearLogs();
    endtask

    task automatic checkPops(input string tag, input logic [31:0] startPc, input int n);
        checkOutput({tag, "_count"}, 32'(popPcLog.size()), 32'(n));
        for (int i = 0; i < n; i++) begin
            if (i < popPcLog.size()) begin
                checkOutput($sformatf("%s_pc%0d", tag, i), popPcLog[i], startPc + 32'(4 * i));
                checkOutput($sformatf("%s_instr%0d", tag, i), popInstrLog[i],
                            (startPc + 32'(4 * i)) ^ 32'hCAFE_0000);
            end
        end
    endtask

    initial begin
        checkCount       = 0;
        errCount         = 0;
        cyc              = 0;
        memLat           = 1;
        rst              = 1'b1;
        i_imem_req_ready = 1'b1;
        i_imem_rsp_valid = 1'b0;
        i_imem_rsp_data  = 32'h0;
        i_redirect       = 1'b0;
        i_redirect_pc    = 32'h0;
        i_instr_ready    = 1'b0;
        req2Ready        = 1'b1;
        rsp2Valid        = 1'b0;
        rsp2Data         = 32'h0;
        redirect2        = 1'b0;
        redirect2Pc      = 32'h0;
        instr2Ready      = 1'b0;
        @(negedge clk);

        // Reset values, sampled in the second reset cycle.
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        checkOutput("rst_req_valid", 32'(snapReqValid), 32'h0);
        checkOutput("rst_req_addr", snapReqAddr, 32'h0);
        checkOutput("rst_instr_valid", 32'(snapInstrValid), 32'h0);
        checkOutput("rst_instr", snapInstr, 32'h0);
        checkOutput("rst_pc", snapPc, 32'h0);
        checkOutput("rst_misaligned", 32'(snapMis), 32'h0);
        checkOutput("rst_pc_wrap", snapPc2, 32'hFFFF_FFF8);
        clearLogs();

        // Streaming with 1-cycle memory.
        for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        checkOutput("stream_req_count", 32'(reqLog.size()), 32'd8);
        for (int i = 0; i < 8; i++) begin
            if (i < reqLog.size()) checkOutput($sformatf("stream_req%0d", i), reqLog[i], 32'(4 * i));
        end
        checkOutput("stream_first_latency", 32'(popCycLog[0] - reqCycLog[0]), 32'd2);
        checkPops("stream", 32'h0, 6);
        checkOutput("wrap_req_count", 32'(req2Log.size()), 32'd4);
        if (req2Log.size() == 4) begin
            checkOutput("wrap_req0", req2Log[0], 32'hFFFF_FFF8);
            checkOutput("wrap_req1", req2Log[1], 32'hFFFF_FFFC);
            checkOutput("wrap_req2", req2Log[2], 32'h0000_0000);
            checkOutput("wrap_req3", req2Log[3], 32'h0000_0004);
        end

        // Decode stalls: buffer fills, issue stops, order resumes intact.
        clearLogs();
        for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("stall_req_count", 32'(reqLog.size()), 32'd0);
        checkOutput("stall_instr_valid", 32'(snapInstrValid), 32'h1);
        checkOutput("stall_head_pc", snapPc, 32'h18);
        clearLogs();
        for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        checkPops("resume", 32'h18, 6);
        checkOutput("resume_req0", reqLog[0], 32'h20);

        // 3-cycle memory, redirect with two requests in flight.
        resetDut();
        memLat = 3;
        for (int i = 0; i < 12; i++) begin
            applyStimulus(1'b0, 1'b1, (i == 2), 32'h100);
            if (i == 2) checkOutput("redir3_no_req", 32'(snapReqValid), 32'h0);
        end
        checkOutput("redir3_req2", reqLog[2], 32'h100);
        checkOutput("redir3_pop0_pc", popPcLog[0], 32'h100);
        checkOutput("redir3_pop0_instr", popInstrLog[0], 32'hCAFE_0100);
        checkOutput("redir3_pop1_pc", popPcLog[1], 32'h104);

        // Redirect coinciding with a response and a would-be request.
        resetDut();
        memLat = 1;
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0, 1'b1, (i == 1), 32'h100);
            if (i == 1) checkOutput("redir1_no_req", 32'(snapReqValid), 32'h0);
            if (i == 2) begin
                checkOutput("redir1_req_valid", 32'(snapReqValid), 32'h1);
                checkOutput("redir1_req_addr", snapReqAddr, 32'h100);
                checkOutput("redir1_flushed", 32'(snapInstrValid), 32'h0);
            end
        end
        checkOutput("redir1_req1", reqLog[1], 32'h100);
        checkOutput("redir1_pop0_pc", popPcLog[0], 32'h100);
        checkOutput("redir1_pop1_pc", popPcLog[1], 32'h104);

        // Misaligned redirect target.
        resetDut();
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b0, 1'b1, (i == 1), 32'h102);
            if (i == 2) begin
`ifdef FETCH_MISALIGN_TRAP_EN
                checkOutput("mis_flag", 32'(snapMis), 32'h1);
                checkOutput("mis_req_valid", 32'(snapReqValid), 32'h0);
`else
                checkOutput("mis_flag", 32'(snapMis), 32'h0);
                checkOutput("mis_req_valid", 32'(snapReqValid), 32'h1);
                checkOutput("mis_req_addr", snapReqAddr, 32'h100);
`endif
            end
        end
`ifdef FETCH_MISALIGN_TRAP_EN
        checkOutput("mis_req_count", 32'(reqLog.size()), 32'd1);
        checkOutput("mis_sticky", 32'(snapMis), 32'h1);
`else
        checkOutput("mis_req_count", 32'(reqLog.size()), 32'd5);
        checkOutput("mis_pop0_pc", popPcLog[0], 32'h100);
`endif

        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule
